load_capture_fifo: RTL and testbench

- Elastic capture stage directly downstream of a flop-driven, buffered hierarchical load path.
- Registers each word arriving from the upstream driver into a small synchronous FIFO.
- Presents the words to the consuming logic through a valid/ready handshake.
- Decouples upstream launch timing from downstream acceptance. Provides occupancy and high-water status for physical-design test benches.

---
 rtl/load_capture_fifo_if.sv | 27 ++
 rtl/load_capture_fifo.sv | 75 +++++++
 tb/tb_load_capture_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/load_capture_fifo_if.sv
// Handshake, data and status bundle for load_capture_fifo; slave = FIFO side, master = upstream/downstream side.
interface load_capture_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  level;
  logic [CNTW-1:0]  hwm;
  logic             hwm_clr;

  modport slave (
    input  in_data, in_valid, out_ready, hwm_clr,
    output in_ready, out_data, out_valid, level, hwm
  );

  modport master (
    output in_data, in_valid, out_ready, hwm_clr,
    input  in_ready, out_data, out_valid, level, hwm
  );
endinterface

// File: rtl/load_capture_fifo.sv
// Elastic capture FIFO with show-ahead valid/ready output; 1-cycle in-to-out, 0 with LOAD_CAPTURE_FIFO_BYPASS_EN when empty.
// Backpressure: in_ready comes from registered occupancy only (never from out_ready), so a full FIFO refuses a push even while popping.
module load_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            CK,
  input  logic            RN,
  load_capture_fifo_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNTW-1:0]  wptr_q, wptr_d;
  logic [CNTW-1:0]  rptr_q, rptr_d;
  logic [CNTW-1:0]  hwm_q, hwm_d;
  logic [CNTW-1:0]  level, level_nx;
  logic             full, empty, in_rdy, push, pop, bypass;
  logic [WIDTH-1:0] out_dat;

  // Pointers carry a wrap bit: equal = empty, equal index with differing wrap = full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign level = wptr_q - rptr_q;

`ifdef LOAD_CAPTURE_FIFO_BYPASS_EN
  assign bypass = RN & empty & bus.in_valid & bus.out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign in_rdy = RN & ~full;
  assign push   = bus.in_valid & in_rdy & ~bypass;
  assign pop    = ~empty & bus.out_ready;

  always_comb begin
    out_dat = '0;
    if (!empty) begin
      out_dat = mem_q[rptr_q[AW-1:0]];
    end else if (bypass) begin
      out_dat = bus.in_data;
    end
  end

  assign wptr_d   = wptr_q + CNTW'(push);
  assign rptr_d   = rptr_q + CNTW'(pop);
  assign level_nx = level + CNTW'(push) - CNTW'(pop);
  // A clear reloads the occupancy after this edge so the current fill is not lost.
  assign hwm_d    = bus.hwm_clr ? level_nx : ((level_nx > hwm_q) ? level_nx : hwm_q);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hwm_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      hwm_q  <= hwm_d;
    end
  end

  always_ff @(posedge CK) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ~empty | bypass;
  assign bus.out_data  = out_dat;
  assign bus.level     = level;
  assign bus.hwm       = hwm_q;
endmodule

// File: tb/tb_load_capture_fifo.sv
// Randomized and directed bench for load_capture_fifo against a queue-based model of the FIFO.
module tb_load_capture_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef LOAD_CAPTURE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CK;
  logic RN;
  int   n_pass = 0;
  int   n_total = 0;
  bit   cmp_en = 1'b0;

  logic [WIDTH-1:0] mq [$];
  int               m_hwm;

  load_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  load_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Reference: a plain queue of stored words plus a running maximum of its size.
  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      mq.delete();
      m_hwm = 0;
    end else begin
      int  n;
      bit  byp, psh, pp;
      n   = mq.size();
      byp = BYP && n == 0 && bus.in_valid && bus.out_ready;
      psh = bus.in_valid && n < DEPTH && !byp;
      pp  = n > 0 && bus.out_ready;
      if (pp) void'(mq.pop_front());
      if (psh) mq.push_back(bus.in_data);
      if (bus.hwm_clr) m_hwm = mq.size();
      else if (mq.size() > m_hwm) m_hwm = mq.size();
    end
  end

  always @(negedge CK) begin
    if (cmp_en) begin
      int               n;
      bit               byp;
      logic [WIDTH-1:0] ed;
      n   = mq.size();
      byp = BYP && RN && n == 0 && bus.in_valid && bus.out_ready;
      ed  = (n != 0) ? mq[0] : (byp ? bus.in_data : '0);
      chk("cyc_in_ready",  32'(bus.in_ready),  32'(RN && n != DEPTH));
      chk("cyc_out_valid", 32'(bus.out_valid), 32'(n != 0 || byp));
      chk("cyc_out_data",  32'(bus.out_data),  32'(ed));
      chk("cyc_level",     32'(bus.level),     32'(n));
      chk("cyc_hwm",       32'(bus.hwm),       32'(m_hwm));
    end
  end

  initial begin
    logic [WIDTH-1:0] fillw [4];
    fillw = '{8'h11, 8'h22, 8'h33, 8'h44};
    RN = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.hwm_clr = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    RN = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_hwm", 32'(bus.hwm), 32'd0);

    // Fill to full; a fifth word is held but refused.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = fillw[i];
      tick();
    end
    bus.in_data = 8'h55;
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_hwm", 32'(bus.hwm), 32'd4);
    chk("full_head", 32'(bus.out_data), 32'h11);
    repeat (2) tick();
    chk("full_hold_level", 32'(bus.level), 32'd4);
    chk("full_hold_head", 32'(bus.out_data), 32'h11);
    bus.in_valid = 1'b0;

    // Drain in order.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(bus.out_data), 32'(fillw[i]));
      tick();
    end
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_level", 32'(bus.level), 32'd0);
    chk("drain_hwm", 32'(bus.hwm), 32'd4);

    // Steady push/pop stream wrapping the pointers three times.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h60;
    tick();
    bus.out_ready = 1'b1;
    for (int i = 1; i < 12; i++) begin
      bus.in_data = 8'(8'h60 + i);
      tick();
      chk("stream_level", 32'(bus.level), 32'd1);
      chk("stream_data", 32'(bus.out_data), 32'(8'h60 + i));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("stream_end_level", 32'(bus.level), 32'd0);

    // hwm clear reloads the current occupancy.
    bus.in_valid = 1'b1;
    bus.in_data = 8'h71;
    tick();
    bus.in_data = 8'h72;
    tick();
    bus.in_valid = 1'b0;
    bus.hwm_clr = 1'b1;
    tick();
    bus.hwm_clr = 1'b0;
    chk("clr_hwm", 32'(bus.hwm), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h73;
    tick();
    bus.in_valid = 1'b0;
    chk("clr_hwm_push", 32'(bus.hwm), 32'd3);
    chk("clr_level", 32'(bus.level), 32'd3);

    // Asynchronous reset between edges.
    #2;
    RN = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) tick();
    RN = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
`ifdef LOAD_CAPTURE_FIFO_BYPASS_EN
    bus.out_ready = 1'b1;
    #1;
    chk("byp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_out_data", 32'(bus.out_data), 32'hA5);
    tick();
    bus.in_valid = 1'b0;
    chk("byp_level", 32'(bus.level), 32'd0);
    chk("byp_hwm", 32'(bus.hwm), 32'd0);
`else
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_data", 32'(bus.out_data), 32'hA5);
    chk("post_rst_level", 32'(bus.level), 32'd1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 99) < 55);
      bus.out_ready = ($urandom_range(0, 99) < 45);
      bus.in_data = 8'($urandom);
      bus.hwm_clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) < 4) begin
        #2;
        RN = 1'b0;
        #2;
        RN = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.hwm_clr = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
